// File: rtl/rob_nway.sv
// N-wide reorder buffer: in-order allocation, out-of-order completion,
// in-order retirement through a registered retire bundle, with full squash.
module rob_nway #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int COMPLETE_W = 3,
  parameter int RETIRE_W   = 2,
  parameter int PREG_W     = 6,
  parameter int DATA_W     = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DISPATCH_W-1:0]                 disp_valid,
  input  logic [DISPATCH_W-1:0]                 disp_has_dest,
  input  logic [DISPATCH_W*PREG_W-1:0]          disp_new_preg,
  input  logic [DISPATCH_W*PREG_W-1:0]          disp_old_preg,
  output logic                                  disp_ready,
  output logic [DISPATCH_W*$clog2(DEPTH)-1:0]   disp_tag,
  input  logic [COMPLETE_W-1:0]                 cmp_valid,
  input  logic [COMPLETE_W*$clog2(DEPTH)-1:0]   cmp_tag,
  input  logic [COMPLETE_W*DATA_W-1:0]          cmp_value,
  input  logic                                  flush,
  output logic [RETIRE_W-1:0]                   ret_valid,
  output logic [RETIRE_W-1:0]                   ret_has_dest,
  output logic [RETIRE_W*PREG_W-1:0]            ret_new_preg,
  output logic [RETIRE_W*PREG_W-1:0]            ret_old_preg,
  output logic [RETIRE_W*DATA_W-1:0]            ret_value,
  output logic [$clog2(RETIRE_W):0]             num_retired,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  empty,
  output logic                                  full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NR_W  = $clog2(RETIRE_W) + 1;
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q, done_q, has_dest_q;
  logic [PREG_W-1:0] new_preg_q [DEPTH];
  logic [PREG_W-1:0] old_preg_q [DEPTH];
  logic [DATA_W-1:0] value_q    [DEPTH];
  logic [IDX_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic [CNT_W:0]    free_slots;
  logic [CNT_W-1:0]  disp_n;
  logic              disp_fire;
  logic [NR_W-1:0]   ret_n;
  logic [RETIRE_W-1:0] ret_go;
  logic [IDX_W-1:0]  ret_idx [RETIRE_W];
  logic              ret_stop;

  // Readiness ignores slots freed by a same-cycle retire.
  assign free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_q};
  assign disp_ready = (free_slots >= (CNT_W+1)'(DISPATCH_W)) && !flush;
  assign disp_fire  = disp_ready && (|disp_valid);
  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));

  always_comb begin
    disp_n   = '0;
    disp_tag = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      disp_tag[i*IDX_W +: IDX_W] = tail_q + disp_n[IDX_W-1:0];
      if (disp_valid[i]) disp_n = disp_n + CNT_W'(1);
    end
  end

  // Retire stops at the first entry from head that is not both valid and done.
  always_comb begin
    ret_n    = '0;
    ret_go   = '0;
    ret_stop = 1'b0;
    for (int k = 0; k < RETIRE_W; k++) begin
      ret_idx[k] = head_q + IDX_W'(k);
      if (!ret_stop && valid_q[ret_idx[k]] && done_q[ret_idx[k]]) begin
        ret_go[k] = 1'b1;
        ret_n     = ret_n + NR_W'(1);
      end else begin
        ret_stop = 1'b1;
      end
    end
  end

  // Later assignments win: completion, then retire clear, then dispatch write.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      done_q       <= '0;
      has_dest_q   <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        new_preg_q[e] <= '0;
        old_preg_q[e] <= '0;
        value_q[e]    <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ret_valid    <= '0;
      ret_has_dest <= '0;
      ret_new_preg <= '0;
      ret_old_preg <= '0;
      ret_value    <= '0;
      num_retired  <= '0;
    end else if (flush) begin
      valid_q      <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ret_valid    <= '0;
      ret_has_dest <= '0;
      ret_new_preg <= '0;
      ret_old_preg <= '0;
      ret_value    <= '0;
      num_retired  <= '0;
    end else begin
      for (int j = 0; j < COMPLETE_W; j++) begin
        if (cmp_valid[j] && valid_q[cmp_tag[j*IDX_W +: IDX_W]]) begin
          done_q[cmp_tag[j*IDX_W +: IDX_W]]  <= 1'b1;
          value_q[cmp_tag[j*IDX_W +: IDX_W]] <= cmp_value[j*DATA_W +: DATA_W];
        end
      end

      for (int k = 0; k < RETIRE_W; k++) begin
        ret_valid[k] <= ret_go[k];
        if (ret_go[k]) begin
          valid_q[ret_idx[k]]                 <= 1'b0;
          done_q[ret_idx[k]]                  <= 1'b0;
          ret_has_dest[k]                     <= has_dest_q[ret_idx[k]];
          ret_new_preg[k*PREG_W +: PREG_W]    <= new_preg_q[ret_idx[k]];
          ret_old_preg[k*PREG_W +: PREG_W]    <= old_preg_q[ret_idx[k]];
          ret_value[k*DATA_W +: DATA_W]       <= value_q[ret_idx[k]];
        end else begin
          ret_has_dest[k]                     <= 1'b0;
          ret_new_preg[k*PREG_W +: PREG_W]    <= '0;
          ret_old_preg[k*PREG_W +: PREG_W]    <= '0;
          ret_value[k*DATA_W +: DATA_W]       <= '0;
        end
      end
      num_retired <= ret_n;

      if (disp_fire) begin
        for (int i = 0; i < DISPATCH_W; i++) begin
          if (disp_valid[i]) begin
            valid_q[disp_tag[i*IDX_W +: IDX_W]]    <= 1'b1;
            done_q[disp_tag[i*IDX_W +: IDX_W]]     <= 1'b0;
            has_dest_q[disp_tag[i*IDX_W +: IDX_W]] <= disp_has_dest[i];
            new_preg_q[disp_tag[i*IDX_W +: IDX_W]] <= disp_new_preg[i*PREG_W +: PREG_W];
            old_preg_q[disp_tag[i*IDX_W +: IDX_W]] <= disp_old_preg[i*PREG_W +: PREG_W];
          end
        end
      end

      head_q  <= head_q + IDX_W'(ret_n);
      tail_q  <= tail_q + (disp_fire ? disp_n[IDX_W-1:0] : '0);
      count_q <= count_q + (disp_fire ? disp_n : '0) - CNT_W'(ret_n);
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: directed scenarios plus random traffic, all checked
// against a program-order queue model of the buffer.
module tb_rob_nway;

  localparam int DEPTH      = 16;
  localparam int DISPATCH_W = 2;
  localparam int COMPLETE_W = 3;
  localparam int RETIRE_W   = 2;
  localparam int PREG_W     = 6;
  localparam int DATA_W     = 32;
  localparam int IDX_W      = 4;
  localparam int NR_W       = 2;

  logic clk = 1'b0;
  logic reset;
  logic [DISPATCH_W-1:0]        disp_valid, disp_has_dest;
  logic [DISPATCH_W*PREG_W-1:0] disp_new_preg, disp_old_preg;
  logic                         disp_ready;
  logic [DISPATCH_W*IDX_W-1:0]  disp_tag;
  logic [COMPLETE_W-1:0]        cmp_valid;
  logic [COMPLETE_W*IDX_W-1:0]  cmp_tag;
  logic [COMPLETE_W*DATA_W-1:0] cmp_value;
  logic                         flush;
  logic [RETIRE_W-1:0]          ret_valid, ret_has_dest;
  logic [RETIRE_W*PREG_W-1:0]   ret_new_preg, ret_old_preg;
  logic [RETIRE_W*DATA_W-1:0]   ret_value;
  logic [NR_W-1:0]              num_retired;
  logic [IDX_W:0]               count;
  logic                         empty, full;

  always #5 clk = ~clk;

  rob_nway #(
    .DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .COMPLETE_W(COMPLETE_W),
    .RETIRE_W(RETIRE_W), .PREG_W(PREG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_has_dest(disp_has_dest),
    .disp_new_preg(disp_new_preg), .disp_old_preg(disp_old_preg),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_value(cmp_value),
    .flush(flush),
    .ret_valid(ret_valid), .ret_has_dest(ret_has_dest),
    .ret_new_preg(ret_new_preg), .ret_old_preg(ret_old_preg),
    .ret_value(ret_value), .num_retired(num_retired),
    .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    int          tag;
    bit          has_dest;
    int          new_preg;
    int          old_preg;
    bit          done;
    int unsigned value;
  } entry_t;

  entry_t              rob_q[$];
  int                  m_tail;
  logic [RETIRE_W-1:0] exp_rv;
  entry_t              exp_ret [RETIRE_W];
  int                  exp_nr;
  int                  n_checks = 0;
  int                  n_fail   = 0;

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Program-order model: the queue front is the oldest entry, m_tail the next tag.
  task automatic modelEdge(
    input logic [DISPATCH_W-1:0] dv, input logic [DISPATCH_W-1:0] dh,
    input logic [DISPATCH_W*PREG_W-1:0] dnew, input logic [DISPATCH_W*PREG_W-1:0] dold,
    input logic [COMPLETE_W-1:0] cv, input logic [COMPLETE_W*IDX_W-1:0] ct,
    input logic [COMPLETE_W*DATA_W-1:0] cval, input logic fl, input logic rst);
    bit     ready;
    int     nret;
    entry_t tmp;
    ready  = !fl && ((DEPTH - rob_q.size()) >= DISPATCH_W);
    exp_rv = '0;
    exp_nr = 0;
    if (rst || fl) begin
      rob_q.delete();
      m_tail = 0;
    end else begin
      nret = 0;
      for (int k = 0; k < RETIRE_W; k++) begin
        if (nret == k && k < rob_q.size()) begin
          if (rob_q[k].done) begin
            exp_ret[k] = rob_q[k];
            exp_rv[k]  = 1'b1;
            nret++;
          end
        end
      end
      for (int j = 0; j < COMPLETE_W; j++) begin
        if (cv[j]) begin
          for (int e = 0; e < rob_q.size(); e++) begin
            if (rob_q[e].tag == int'(ct[j*IDX_W +: IDX_W])) begin
              tmp       = rob_q[e];
              tmp.done  = 1'b1;
              tmp.value = cval[j*DATA_W +: DATA_W];
              rob_q[e]  = tmp;
            end
          end
        end
      end
      repeat (nret) void'(rob_q.pop_front());
      if (ready && (|dv)) begin
        for (int i = 0; i < DISPATCH_W; i++) begin
          if (dv[i]) begin
            tmp.tag      = m_tail;
            tmp.has_dest = dh[i];
            tmp.new_preg = int'(dnew[i*PREG_W +: PREG_W]);
            tmp.old_preg = int'(dold[i*PREG_W +: PREG_W]);
            tmp.done     = 1'b0;
            tmp.value    = 0;
            rob_q.push_back(tmp);
            m_tail = (m_tail + 1) % DEPTH;
          end
        end
      end
      exp_nr = nret;
    end
  endtask

  // One clock: drive inputs, check combinational outputs, clock, check registered outputs.
  task automatic applyStimulus(
    input logic [DISPATCH_W-1:0] dv, input logic [DISPATCH_W-1:0] dh,
    input logic [DISPATCH_W*PREG_W-1:0] dnew, input logic [DISPATCH_W*PREG_W-1:0] dold,
    input logic [COMPLETE_W-1:0] cv, input logic [COMPLETE_W*IDX_W-1:0] ct,
    input logic [COMPLETE_W*DATA_W-1:0] cval, input logic fl, input logic rst);
    int off;
    disp_valid = dv; disp_has_dest = dh; disp_new_preg = dnew; disp_old_preg = dold;
    cmp_valid = cv; cmp_tag = ct; cmp_value = cval; flush = fl; reset = rst;
    #1;
    if (!rst) begin
      checkOutput("disp_ready", disp_ready, !fl && ((DEPTH - rob_q.size()) >= DISPATCH_W));
      checkOutput("empty", empty, rob_q.size() == 0);
      checkOutput("full", full, rob_q.size() == DEPTH);
      off = 0;
      for (int i = 0; i < DISPATCH_W; i++) begin
        if (dv[i]) begin
          checkOutput($sformatf("disp_tag%0d", i), disp_tag[i*IDX_W +: IDX_W], (m_tail + off) % DEPTH);
          off++;
        end
      end
    end
    @(posedge clk);
    modelEdge(dv, dh, dnew, dold, cv, ct, cval, fl, rst);
    #1;
    checkOutput("count", count, rob_q.size());
    checkOutput("ret_valid", ret_valid, exp_rv);
    checkOutput("num_retired", num_retired, exp_nr);
    for (int k = 0; k < RETIRE_W; k++) begin
      if (exp_rv[k]) begin
        checkOutput($sformatf("ret_has_dest%0d", k), ret_has_dest[k], exp_ret[k].has_dest);
        checkOutput($sformatf("ret_new_preg%0d", k), ret_new_preg[k*PREG_W +: PREG_W], exp_ret[k].new_preg);
        checkOutput($sformatf("ret_old_preg%0d", k), ret_old_preg[k*PREG_W +: PREG_W], exp_ret[k].old_preg);
        checkOutput($sformatf("ret_value%0d", k), ret_value[k*DATA_W +: DATA_W], exp_ret[k].value);
      end
    end
  endtask

  task automatic resetDut();
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
    checkOutput("reset_empty", empty, 1'b1);
    checkOutput("reset_full", full, 1'b0);
    checkOutput("reset_ready", disp_ready, 1'b1);
  endtask

  initial begin
    logic [DISPATCH_W-1:0]        dv, dh;
    logic [DISPATCH_W*PREG_W-1:0] dnew, dold;
    logic [COMPLETE_W-1:0]        cv;
    logic [COMPLETE_W*IDX_W-1:0]  ct;
    logic [COMPLETE_W*DATA_W-1:0] cval;
    logic                         fl, rst;

    m_tail = 0;
    reset = 1'b1; flush = 1'b0;
    disp_valid = '0; disp_has_dest = '0; disp_new_preg = '0; disp_old_preg = '0;
    cmp_valid = '0; cmp_tag = '0; cmp_value = '0;

    // Two entries complete out of order and retire together.
    resetDut();
    applyStimulus(2'b11, 2'b11, {6'd34, 6'd33}, {6'd2, 6'd1}, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, '0, 3'b001, {4'd0, 4'd0, 4'd1}, {32'd0, 32'd0, 32'hAA}, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, '0, 3'b001, {4'd0, 4'd0, 4'd0}, {32'd0, 32'd0, 32'h55}, 1'b0, 1'b0);
    checkOutput("no_early_retire", ret_valid, 2'b00);
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("pair_ret_value", ret_value, 64'h0000_00AA_0000_0055);
    checkOutput("pair_num_retired", num_retired, 2);
    checkOutput("pair_new_preg", ret_new_preg, {6'd34, 6'd33});

    // Fill to capacity, then a blocked request.
    resetDut();
    repeat (8) applyStimulus(2'b11, 2'b01, $urandom, $urandom, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("fill_count", count, 16);
    checkOutput("fill_full", full, 1'b1);
    checkOutput("fill_ready", disp_ready, 1'b0);
    applyStimulus(2'b11, 2'b11, $urandom, $urandom, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("fill_blocked_count", count, 16);

    // Steady state across the pointer wrap.
    resetDut();
    for (int c = 0; c < 10; c++) begin
      cv = '0; ct = '0;
      for (int j = 0; j < 2; j++) begin
        if (j < rob_q.size()) begin
          cv[j] = 1'b1;
          ct[j*IDX_W +: IDX_W] = IDX_W'(rob_q[j].tag);
        end
      end
      applyStimulus(2'b11, $urandom, $urandom, $urandom, cv, ct,
                    {$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    end

    // Sparse dispatch lanes and a duplicate completion tag.
    resetDut();
    applyStimulus(2'b10, 2'b10, {6'd7, 6'd0}, {6'd3, 6'd0}, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, '0, 3'b101, {4'd0, 4'd0, 4'd0}, {32'd9, 32'd0, 32'd5}, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("dup_value", ret_value[DATA_W-1:0], 9);
    checkOutput("sparse_preg", ret_new_preg[PREG_W-1:0], 7);

    // Flush beats a simultaneous dispatch and completion.
    resetDut();
    repeat (3) applyStimulus(2'b11, 2'b11, $urandom, $urandom, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, '0, 3'b111, {4'd5, 4'd4, 4'd3}, {$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, $urandom, $urandom, 3'b001, '0, {3{32'h1}}, 1'b1, 1'b0);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_empty", empty, 1'b1);
    checkOutput("flush_ret_valid", ret_valid, 2'b00);
    applyStimulus(2'b01, 2'b01, $urandom, $urandom, '0, '0, '0, 1'b0, 1'b0);

    // Reset on the edge where two entries would retire.
    resetDut();
    applyStimulus(2'b11, 2'b11, $urandom, $urandom, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, '0, 3'b011, {4'd0, 4'd1, 4'd0}, {$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1);
    checkOutput("rst_mid_ret_valid", ret_valid, 2'b00);
    checkOutput("rst_mid_count", count, 0);

    // Random traffic.
    resetDut();
    for (int n = 0; n < 600; n++) begin
      dv   = DISPATCH_W'($urandom_range(3));
      dh   = DISPATCH_W'($urandom);
      dnew = $urandom;
      dold = $urandom;
      cv   = COMPLETE_W'($urandom_range(7));
      ct   = '0;
      for (int j = 0; j < COMPLETE_W; j++) begin
        if (rob_q.size() > 0 && $urandom_range(3) != 0)
          ct[j*IDX_W +: IDX_W] = IDX_W'(rob_q[$urandom_range(rob_q.size() - 1)].tag);
        else
          ct[j*IDX_W +: IDX_W] = IDX_W'($urandom_range(DEPTH - 1));
      end
      cval = {$urandom, $urandom, $urandom};
      fl   = ($urandom_range(39) == 0);
      rst  = ($urandom_range(99) == 0);
      applyStimulus(dv, dh, dnew, dold, cv, ct, cval, fl, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_nway.md
# rob_nway

Parametrised N-wide reorder buffer for the out-of-order core. It sits between rename/dispatch and writeback and generalises the fixed 2-in/2-out ROB to configurable depth, dispatch width, completion width and retire width. It adds a flush mode for squashing all in-flight entries. Entries are allocated in program order, marked complete out of order by the functional-unit result lanes, and retired in order with a registered retire bundle. Writeback uses that bundle to update the register file and free old physical registers.

## Interface
- DEPTH, 16: entry count; power of two, at least 4; IDX_W = log2(DEPTH).
- DISPATCH_W, 2: dispatch lanes per cycle; must not exceed DEPTH.
- COMPLETE_W, 3: completion lanes per cycle (one per functional unit).
- RETIRE_W, 2: maximum retirements per cycle.
- PREG_W, 6: physical register index width.
- DATA_W, 32: result value width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- disp_valid  in  DISPATCH_W  per-lane dispatch request.
- disp_has_dest  in  DISPATCH_W  per lane; 1 = the instruction writes a destination register.
- disp_new_preg  in  DISPATCH_W*PREG_W  newly mapped destination preg, lane i at [i*PREG_W +: PREG_W].
- disp_old_preg  in  DISPATCH_W*PREG_W  previous mapping, freed at retire.
- disp_ready  out  1  combinational: (DEPTH - count) >= DISPATCH_W and !flush.
- disp_tag  out  DISPATCH_W*IDX_W  combinational tag allocated to each lane.
- cmp_valid  in  COMPLETE_W  per-lane completion.
- cmp_tag  in  COMPLETE_W*IDX_W  ROB tag being completed.
- cmp_value  in  COMPLETE_W*DATA_W  result value.
- flush  in  1  squash all entries.
- ret_valid  out  RETIRE_W  registered; contiguous from lane 0.
- ret_has_dest, ret_new_preg, ret_old_preg, ret_value  out  per-lane packed  registered retire bundle.
- num_retired  out  log2(RETIRE_W)+1  registered popcount of ret_valid.
- count  out  IDX_W+1  registered occupancy.
- empty, full  out  1  combinational: count==0 and count==DEPTH.

## Operation
- State per entry: valid, done, has_dest, new_preg, old_preg, value.
- State pointers: head, tail (IDX_W bits, wrap modulo DEPTH); count.
- Dispatch is accepted on an edge when disp_ready and at least one disp_valid bit is set.
  - Valid lanes are compacted in lane order.
  - A valid lane i takes tag = tail + (number of valid lanes below i).
  - disp_tag for invalid lanes is don't-care.
  - Entries are written with valid=1, done=0.
  - tail and count advance by popcount(disp_valid).
- Dispatch is all-or-nothing. When disp_ready=0, no lane is accepted and no state changes.
- Completion for each valid lane whose tag hits a valid entry sets done=1 and stores the value.
  - A completion to an invalid entry is ignored.
  - If several lanes carry the same tag in one cycle, the highest lane index wins.
- Retire scans k = 0..RETIRE_W-1 from head and stops at the first entry that is not (valid && done).
  - Retired entries are cleared; head advances by the number retired; count drops by the same amount.
  - The retire bundle registers the cleared entries' fields; lanes not retired have ret_valid=0.
- When dispatch and retire happen on the same edge, count' = count + dispatched - retired.
  - disp_ready uses the pre-edge count; a slot freed by retire is not credited the same cycle.
- Flush has priority over dispatch, completion and retire on that edge.
  - Effect: all valid bits cleared, head=tail=0, count=0, ret_valid=0, num_retired=0.
- Reset has the same effect as flush. In addition, every output bundle field and every entry field resets to 0.
- After reset: disp_ready=1, empty=1, full=0.
- Reset asserted mid-operation discards all in-flight entries; nothing retires on that edge.

## Timing
- disp_tag and disp_ready are valid in the same cycle as disp_valid, so rename can tag reservation-station entries.
- There is no completion-to-retire bypass. A completion sampled on edge k makes the entry eligible on edge k+1, and ret_valid is high in the cycle after edge k+1.
- A completion on the same edge an entry is dispatched is ignored; the entry is not yet valid.
- Retire outputs are held for exactly one cycle per retirement and are 0 in cycles with no retirement.
- Full: with DEPTH - count < DISPATCH_W, disp_ready=0 even if fewer lanes are valid.
- Empty: retire scan yields 0; the outputs stay at ret_valid=0.
- Wrap-around: the pointers roll from DEPTH-1 to 0; tag allocation and the retire scan wrap modulo DEPTH.

## Test plan
- **Reset:** assert reset, then dispatch 2 lanes with new_preg 33/34 and old_preg 1/2 at tags 0/1. Complete tag 1 with value 0xAA, then tag 0 with 0x55. Required: no retire until tag 0 completes. Both then retire in one cycle with ret_value {0x55, 0xAA} and num_retired=2.
- **Fill:** DEPTH=16, DISPATCH_W=2, nothing completes. After 8 dispatch cycles: count=16, full=1, disp_ready=0. A 9th request changes nothing.
- **Wrap:** cycle 20 entries through at steady state (dispatch 2, retire 2). Required: tags wrap 14, 15, 0, 1 and the retire order matches dispatch order.
- **Sparse lanes / duplicate completion:** disp_valid=2'b10 gets tag=tail and tail+=1. Complete the same tag on lanes 0 and 2 with values 5 and 9 in one cycle. Required: retired value 9.
- **Flush:** with 6 entries (3 done), assert flush together with a dispatch and a completion. Required next cycle: count=0, empty=1, ret_valid=0, and the next dispatch gets tag 0.
- **Reset mid-retire:** assert reset on the edge where 2 entries would retire. Required: ret_valid=0 and count=0 next cycle.
